rx_buffer_drain_ctrl: RTL and testbench

Sequencer for the 224-bit receive output buffer (7 x 32-bit words). When the buffer reports full, it reads the 7 words in order (addr 0..6, MSW first) and streams them out on a valid/ready master interface. It then performs the tx_done flag handshake (write 1, wait for full to drop, write 0) so the buffer clears and re-arms. It sits between the buffer's read/flag ports and the downstream packet sink.

---
 rtl/rx_buffer_drain_ctrl.sv | 160 ++++++++++++++++
 tb/tb_rx_buffer_drain_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_buffer_drain_ctrl.sv
`default_nettype none
// ============================================================================
// rx_buffer_drain_ctrl : drains the full rx buffer onto a valid/ready stream,
// then runs the tx_done flag handshake. Optional header beat: DRAIN_HDR_EN.
// Revision: 1.0
// ============================================================================
module rx_buffer_drain_ctrl #(
  parameter int NUM_WORDS = 7,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              buff_full,
  output logic              buf_read_ena,
  output logic [2:0]        buf_read_addr,
  input  logic [DATA_W-1:0] buf_dout,
  output logic              flag_write_ena,
  output logic              flag_addres,
  output logic [31:0]       flag_data,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [2:0] LAST_ADDR = 3'(NUM_WORDS - 1);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_IDLE     = 4'd1,
    S_HDR      = 4'd2,
    S_RD_REQ   = 4'd3,
    S_RD_WAIT  = 4'd4,
    S_PUSH     = 4'd5,
    S_FLAG_SET = 4'd6,
    S_WAIT_CLR = 4'd7,
    S_FLAG_CLR = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        addr_q, addr_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
  logic              m_tlast_q, m_tlast_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic              rd_ena_q, rd_ena_d;
  logic              flag_we_q, flag_we_d;
  logic              flag_val_q, flag_val_d;
  logic              busy_q, busy_d;

`ifdef DRAIN_HDR_EN
  logic [31:0] hdr_raw;
  assign hdr_raw = {16'hA5C3, 16'(frame_cnt_q)};
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    frame_cnt_d = frame_cnt_q;
    m_tdata_d   = m_tdata_q;
    m_tlast_d   = m_tlast_q;
    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (enable && buff_full) begin
          addr_d = '0;
`ifdef DRAIN_HDR_EN
          state_d   = S_HDR;
          m_tdata_d = DATA_W'(hdr_raw);
          m_tlast_d = 1'b0;
`else
          state_d   = S_RD_REQ;
`endif
        end
      end
`ifdef DRAIN_HDR_EN
      S_HDR: begin
        if (m_tvalid_q && m_tready) state_d = S_RD_REQ;
      end
`endif
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        // buf_dout is valid now, one cycle after the read strobe
        m_tdata_d = buf_dout;
        m_tlast_d = (addr_q == LAST_ADDR);
        state_d   = S_PUSH;
      end
      S_PUSH: begin
        if (m_tvalid_q && m_tready) begin
          m_tlast_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_d = S_FLAG_SET;
          end else begin
            addr_d  = addr_q + 3'd1;
            state_d = S_RD_REQ;
          end
        end
      end
      S_FLAG_SET: state_d = S_WAIT_CLR;
      S_WAIT_CLR: begin
        if (!buff_full) begin
          state_d     = S_FLAG_CLR;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      S_FLAG_CLR: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    rd_ena_d   = (state_d == S_RD_REQ);
    flag_we_d  = (state_q == S_INIT) || (state_d == S_FLAG_SET) || (state_d == S_FLAG_CLR);
    flag_val_d = (state_d == S_FLAG_SET);
    m_tvalid_d = (state_d == S_PUSH) || (state_d == S_HDR);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      addr_q      <= '0;
      frame_cnt_q <= '0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tvalid_q  <= 1'b0;
      rd_ena_q    <= 1'b0;
      flag_we_q   <= 1'b0;
      flag_val_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      frame_cnt_q <= frame_cnt_d;
      m_tdata_q   <= m_tdata_d;
      m_tlast_q   <= m_tlast_d;
      m_tvalid_q  <= m_tvalid_d;
      rd_ena_q    <= rd_ena_d;
      flag_we_q   <= flag_we_d;
      flag_val_q  <= flag_val_d;
      busy_q      <= busy_d;
    end
  end

  assign buf_read_ena   = rd_ena_q;
  assign buf_read_addr  = addr_q;
  assign flag_write_ena = flag_we_q;
  assign flag_addres    = 1'b0;
  assign flag_data      = {31'd0, flag_val_q};
  assign m_tdata        = m_tdata_q;
  assign m_tvalid       = m_tvalid_q;
  assign m_tlast        = m_tlast_q;
  assign busy           = busy_q;
  assign frame_cnt      = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_buffer_drain_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rx_buffer_drain_ctrl : buffer model + scoreboard for rx_buffer_drain_ctrl.
// Revision: 1.0
// ============================================================================
module tb_rx_buffer_drain_ctrl;
  localparam int NUM_WORDS = 7;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 16;
`ifdef DRAIN_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int BEATS = NUM_WORDS + HDR;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              buff_full = 1'b0;
  logic              buf_read_ena;
  logic [2:0]        buf_read_addr;
  logic [DATA_W-1:0] buf_dout = '0;
  logic              flag_write_ena;
  logic              flag_addres;
  logic [31:0]       flag_data;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic              m_tlast;
  logic              busy;
  logic [CNT_W-1:0]  frame_cnt;

  rx_buffer_drain_ctrl #(.NUM_WORDS(NUM_WORDS), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .buff_full(buff_full),
    .buf_read_ena(buf_read_ena), .buf_read_addr(buf_read_addr), .buf_dout(buf_dout),
    .flag_write_ena(flag_write_ena), .flag_addres(flag_addres), .flag_data(flag_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              l;
  } beat_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ready_mode = 1;  // 0 low, 1 high, 2 random
  beat_t       exp_q[$];
  logic [31:0] ld_q[$];
  logic [31:0] flag_log[$];
  logic [15:0] exp_frames = '0;
  logic [31:0] cur_words[NUM_WORDS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: registered read port, full drops 2 cycles after tx_done=1.
  logic [31:0] mem[8];
  logic        armed = 1'b0;
  logic        clr_pend = 1'b0;
  always @(posedge clk) begin
    if (buf_read_ena) buf_dout <= mem[buf_read_addr];
    if (clr_pend) begin
      buff_full <= 1'b0;
      clr_pend  <= 1'b0;
    end
    if (flag_write_ena) begin
      if (flag_data == 32'd1) clr_pend <= 1'b1;
      else armed <= 1'b1;
    end
    if (armed && !buff_full && !clr_pend && ld_q.size() >= NUM_WORDS) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= ld_q.pop_front();
      buff_full <= 1'b1;
      armed     <= 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] prev_d;
  logic              prev_l;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (buf_read_ena || flag_write_ena)
        chk("rd_flag_excl", 64'(buf_read_ena & flag_write_ena), 64'd0);
      if (flag_write_ena) begin
        chk("flag_addr", 64'(flag_addres), 64'd0);
        flag_log.push_back(flag_data);
      end
      if (stall_prev) begin
        chk("hold_valid", 64'(m_tvalid), 64'd1);
        chk("hold_data", 64'(m_tdata), 64'(prev_d));
        chk("hold_last", 64'(m_tlast), 64'(prev_l));
      end
      if (m_tvalid && m_tready) begin
        stall_prev = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", m_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", 64'(m_tdata), 64'(e.d));
          chk("beat_last", 64'(m_tlast), 64'(e.l));
        end
      end else if (m_tvalid) begin
        stall_prev = 1'b1;
        prev_d     = m_tdata;
        prev_l     = m_tlast;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic push_exp();
    beat_t b;
    if (HDR != 0) begin
      b.d = {16'hA5C3, exp_frames};
      b.l = 1'b0;
      exp_q.push_back(b);
    end
    for (int i = 0; i < NUM_WORDS; i++) begin
      b.d = cur_words[i];
      b.l = (i == NUM_WORDS - 1);
      exp_q.push_back(b);
    end
    exp_frames = exp_frames + 16'd1;
  endtask

  task automatic load_frame(input logic [31:0] base, input bit rnd);
    for (int i = 0; i < NUM_WORDS; i++) begin
      cur_words[i] = rnd ? $urandom : base + 32'(i);
      ld_q.push_back(cur_words[i]);
    end
    push_exp();
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (n < bound && !(exp_q.size() == 0 && ld_q.size() == 0 && !busy && !buff_full)) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= bound) fail("idle_timeout");
  endtask

  task automatic wait_busy(input int bound, output int t);
    int n = 0;
    while (n < bound && !busy) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= bound) fail("busy_timeout");
    t = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int t0;
    int t1;
    int n;

    // Reset and INIT
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_flag_we", 64'(flag_write_ena), 64'd0);
    chk("rst_cnt", 64'(frame_cnt), 64'd0);
    flag_log.delete();
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("init_flag_n", 64'(flag_log.size()), 64'd1);
    chk("init_flag_val", 64'((flag_log.size() > 0) ? flag_log[0] : 32'hdead), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_tvalid", 64'(m_tvalid), 64'd0);
    chk("idle_cnt", 64'(frame_cnt), 64'd0);

    // Plain frame 0..6, ready high, latency to tx_done set
    ready_mode = 1;
    enable = 1'b1;
    flag_log.delete();
    load_frame(32'd0, 1'b0);
    wait_busy(50, t0);
    n = 0;
    while (n < 100 && !(flag_write_ena && flag_data == 32'd1)) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 100) fail("flag_set_timeout");
    t1 = cyc;
    chk("flag_latency", 64'(t1 - t0), 64'(3 * NUM_WORDS + HDR));
    wait_idle(200);
    chk("cnt_frame1", 64'(frame_cnt), 64'(exp_frames));
    chk("flag_seq_n", 64'(flag_log.size()), 64'd2);
    chk("flag_seq_set", 64'((flag_log.size() > 1) ? flag_log[0] : 32'hdead), 64'd1);
    chk("flag_seq_clr", 64'((flag_log.size() > 1) ? flag_log[1] : 32'hdead), 64'd0);

    // Random data with random backpressure, back-to-back frames
    ready_mode = 2;
    for (int r = 0; r < 2; r++) begin
      load_frame(32'd0, 1'b1);
      load_frame(32'd0, 1'b1);
      wait_idle(1500);
      chk("cnt_random", 64'(frame_cnt), 64'(exp_frames));
    end

    // enable dropped mid-frame
    ready_mode = 1;
    load_frame(32'd0, 1'b1);
    wait_busy(50, t0);
    repeat (2) @(posedge clk);
    #2;
    enable = 1'b0;
    wait_idle(300);
    chk("cnt_en_drop", 64'(frame_cnt), 64'(exp_frames));
    load_frame(32'd0, 1'b1);
    repeat (40) @(posedge clk);
    #2;
    chk("hold_off_busy", 64'(busy), 64'd0);
    chk("hold_off_beats", 64'(exp_q.size()), 64'(BEATS));
    chk("hold_off_cnt", 64'(frame_cnt), 64'(exp_frames - 16'd1));
    enable = 1'b1;
    wait_idle(300);
    chk("cnt_en_resume", 64'(frame_cnt), 64'(exp_frames));

    // Async reset while stalled in PUSH of word 3
    load_frame(32'd0, 1'b1);
    n = 0;
    while (n < 200 && !(buf_read_ena && buf_read_addr == 3'd3)) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) fail("word3_timeout");
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("stall_valid", 64'(m_tvalid), 64'd1);
    chk("stall_addr", 64'(buf_read_addr), 64'd3);
    chk("stall_data", 64'(m_tdata), 64'(cur_words[3]));
    #1;
    rst = 1'b1;
    #1;
    chk("arst_tvalid", 64'(m_tvalid), 64'd0);
    chk("arst_tlast", 64'(m_tlast), 64'd0);
    chk("arst_tdata", 64'(m_tdata), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_rd", 64'(buf_read_ena), 64'd0);
    chk("arst_cnt", 64'(frame_cnt), 64'd0);
    exp_q.delete();
    flag_log.delete();
    exp_frames = '0;
    push_exp();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    ready_mode = 1;
    wait_idle(300);
    chk("cnt_after_rst", 64'(frame_cnt), 64'd1);
    chk("rst_flag_n", 64'(flag_log.size()), 64'd3);
    chk("rst_flag_init", 64'((flag_log.size() > 2) ? flag_log[0] : 32'hdead), 64'd0);
    chk("rst_flag_set", 64'((flag_log.size() > 2) ? flag_log[1] : 32'hdead), 64'd1);
    chk("rst_flag_clr", 64'((flag_log.size() > 2) ? flag_log[2] : 32'hdead), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
